// File: rtl/game_pkg.sv
// game_pkg: types and constants shared by the game-flow controller.
//   state_t  : game flow states
//   DEF_X_W  : default grid x coordinate width
//   DEF_Y_W  : default grid y coordinate width
//   LIVES_W  : width of the lives counter
package game_pkg;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    PLAY   = 3'd1,
    RESUME = 3'd2,
    OVER   = 3'd3,
    WIN    = 3'd4
  } state_t;

  localparam int DEF_X_W = 6;
  localparam int DEF_Y_W = 5;
  localparam int LIVES_W = 3;

endpackage

// File: rtl/game_state_ctrl_countdown_timer.sv
// countdown_timer: saturating down-counter with terminal-count flag.
//   clk_sys, rst_b : clock, async active-low reset
//   load           : load CYCLES-1 (wins over enable)
//   enable         : decrement by one while non-zero
//   clear          : force count to 0 (wins over load)
//   zero           : count == 0
module countdown_timer #(
  parameter int CYCLES = 4
) (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic load,
  input  logic enable,
  input  logic clear,
  output logic zero
);

  localparam int W = $clog2(CYCLES > 2 ? CYCLES : 2);
  localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (enable && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: Pac-Man game-flow sequencer.
//   Inputs : CLOCK_50, reset_n, start (level), power_pill (pulse),
//            all_pills (level), pac_x/pac_y, ghost_x/ghost_y (ghost i in slice i)
//   Outputs: state, lives, sprite_reset, map_wr_reset, ghost_enable,
//            frightened, ghost_eaten (pulse per ghost), life_lost (pulse)
//
//   state  | meaning
//   INIT   | reload lives, hold sprites and map writer, wait for start
//   PLAY   | normal play, collisions cost a life or eat a ghost
//   RESUME | timed hold after a lost life, sprites parked at home
//   OVER   | no lives left, wait for a fresh start press
//   WIN    | all pills eaten, wait for a fresh start press
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int NUM_GHOSTS    = 2,
  parameter int X_W           = DEF_X_W,
  parameter int Y_W           = DEF_Y_W,
  parameter int LIVES_INIT    = 3,
  parameter int RESUME_CYCLES = 250000000,
  parameter int POWER_CYCLES  = 400000000
) (
  input  logic                      CLOCK_50,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      power_pill,
  input  logic                      all_pills,
  input  logic [X_W-1:0]            pac_x,
  input  logic [Y_W-1:0]            pac_y,
  input  logic [NUM_GHOSTS*X_W-1:0] ghost_x,
  input  logic [NUM_GHOSTS*Y_W-1:0] ghost_y,
  output state_t                    state,
  output logic [LIVES_W-1:0]        lives,
  output logic                      sprite_reset,
  output logic                      map_wr_reset,
  output logic                      ghost_enable,
  output logic                      frightened,
  output logic [NUM_GHOSTS-1:0]     ghost_eaten,
  output logic                      life_lost
);

  state_t                state_next;
  logic [LIVES_W-1:0]    lives_next;
  logic                  life_lost_next;
  logic [NUM_GHOSTS-1:0] eaten_next;
  logic [NUM_GHOSTS-1:0] coll, coll_q, hit;
  logic                  start_q;
  logic                  res_load, res_zero;
  logic                  pwr_load, pwr_zero;
  logic                  timers_clear;

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_coll
    assign coll[g] = (ghost_x[g*X_W +: X_W] == pac_x) &&
                     (ghost_y[g*Y_W +: Y_W] == pac_y);
  end

  // Only the first cycle of an overlap acts.
  assign hit = coll & ~coll_q;

  always_comb begin
    state_next     = state;
    lives_next     = lives;
    life_lost_next = 1'b0;
    eaten_next     = '0;
    res_load       = 1'b0;
    unique case (state)
      INIT: begin
        lives_next = LIVES_W'(LIVES_INIT);
        if (start) state_next = PLAY;
      end
      PLAY: begin
        if (all_pills) begin
          state_next = WIN;
        end else if (frightened) begin
          eaten_next = hit;
        end else if (|hit) begin
          life_lost_next = 1'b1;
          if (lives > LIVES_W'(1)) begin
            lives_next = lives - LIVES_W'(1);
            res_load   = 1'b1;
            state_next = RESUME;
          end else begin
            lives_next = '0;
            state_next = OVER;
          end
        end
      end
      RESUME: begin
        if (res_zero) state_next = PLAY;
      end
      OVER, WIN: begin
        // Edge-qualified so a start held from the last game is ignored.
        if (start && !start_q) state_next = INIT;
      end
      default: state_next = INIT;
    endcase
  end

  // A pill is dropped if the same cycle's hit or all_pills leaves PLAY.
  assign pwr_load     = (state == PLAY) && power_pill && (state_next == PLAY);
  assign timers_clear = (state_next == INIT) || (state_next == OVER) ||
                        (state_next == WIN);

  countdown_timer #(.CYCLES(RESUME_CYCLES)) u_resume_timer (
    .clk_sys (CLOCK_50),
    .rst_b   (reset_n),
    .load    (res_load),
    .enable  (state == RESUME),
    .clear   (timers_clear),
    .zero    (res_zero)
  );

  countdown_timer #(.CYCLES(POWER_CYCLES)) u_power_timer (
    .clk_sys (CLOCK_50),
    .rst_b   (reset_n),
    .load    (pwr_load),
    .enable  (state == PLAY),
    .clear   (timers_clear),
    .zero    (pwr_zero)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= INIT;
      lives       <= LIVES_W'(LIVES_INIT);
      life_lost   <= 1'b0;
      ghost_eaten <= '0;
      coll_q      <= '0;
      start_q     <= 1'b0;
    end else begin
      state       <= state_next;
      lives       <= lives_next;
      life_lost   <= life_lost_next;
      ghost_eaten <= eaten_next;
      coll_q      <= coll;
      start_q     <= start;
    end
  end

  // Frightened drops on the PLAY cycle the timer already sits at zero, which
  // keeps it high for the full POWER_CYCLES after the load.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      frightened <= 1'b0;
    end else if (timers_clear) begin
      frightened <= 1'b0;
    end else if (pwr_load) begin
      frightened <= 1'b1;
    end else if (state == PLAY && pwr_zero) begin
      frightened <= 1'b0;
    end
  end

  always_comb begin
    sprite_reset = 1'b0;
    map_wr_reset = 1'b0;
    ghost_enable = 1'b0;
    unique case (state)
      INIT:      begin sprite_reset = 1'b1; map_wr_reset = 1'b1; end
      PLAY:      ghost_enable = 1'b1;
      RESUME:    sprite_reset = 1'b1;
      OVER, WIN: map_wr_reset = 1'b1;
      default:   begin sprite_reset = 1'b1; map_wr_reset = 1'b1; end
    endcase
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
module tb_game_state_ctrl;
  import game_pkg::*;

  localparam int NG    = 3;
  localparam int XW    = 6;
  localparam int YW    = 5;
  localparam int LIVES = 3;
  localparam int RES   = 4;
  localparam int POWER = 8;

  logic           CLOCK_50 = 1'b0;
  logic           reset_n, start, power_pill, all_pills;
  logic [XW-1:0]  pac_x;
  logic [YW-1:0]  pac_y;
  logic [NG*XW-1:0] ghost_x;
  logic [NG*YW-1:0] ghost_y;
  state_t         state;
  logic [2:0]     lives;
  logic           sprite_reset, map_wr_reset, ghost_enable, frightened, life_lost;
  logic [NG-1:0]  ghost_eaten;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  state_t        m_state;
  int            m_lives, m_power, m_resume;
  logic [NG-1:0] m_prev, m_eaten;
  logic          m_lost, m_start_prev;

  game_state_ctrl #(
    .NUM_GHOSTS(NG), .X_W(XW), .Y_W(YW), .LIVES_INIT(LIVES),
    .RESUME_CYCLES(RES), .POWER_CYCLES(POWER)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start),
    .power_pill(power_pill), .all_pills(all_pills),
    .pac_x(pac_x), .pac_y(pac_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
    .state(state), .lives(lives), .sprite_reset(sprite_reset),
    .map_wr_reset(map_wr_reset), .ghost_enable(ghost_enable),
    .frightened(frightened), .ghost_eaten(ghost_eaten), .life_lost(life_lost)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] dut_vec();
    return {state, lives, sprite_reset, map_wr_reset, ghost_enable,
            frightened, ghost_eaten, life_lost};
  endfunction

  function automatic logic [13:0] exp_vec();
    logic [2:0] ctrl;
    case (m_state)
      INIT:    ctrl = 3'b110;
      PLAY:    ctrl = 3'b001;
      RESUME:  ctrl = 3'b100;
      default: ctrl = 3'b010;
    endcase
    return {m_state, 3'(m_lives), ctrl, (m_power > 0), m_eaten, m_lost};
  endfunction

  task automatic model_reset();
    m_state = INIT; m_lives = LIVES; m_power = 0; m_resume = 0;
    m_prev = '0; m_eaten = '0; m_lost = 1'b0; m_start_prev = 1'b0;
  endtask

  // One clock of game rules, evaluated on the inputs present this cycle.
  task automatic model_step();
    logic [NG-1:0] coll, hit;
    for (int i = 0; i < NG; i++)
      coll[i] = (ghost_x[i*XW +: XW] == pac_x) && (ghost_y[i*YW +: YW] == pac_y);
    hit = coll & ~m_prev;
    m_eaten = '0;
    m_lost  = 1'b0;
    case (m_state)
      INIT: begin
        m_lives = LIVES; m_power = 0;
        if (start) m_state = PLAY;
      end
      PLAY: begin
        if (all_pills) begin
          m_state = WIN; m_power = 0;
        end else if (m_power > 0) begin
          m_eaten = hit;
          m_power = power_pill ? POWER : m_power - 1;
        end else if (hit != '0) begin
          m_lost = 1'b1;
          if (m_lives > 1) begin
            m_lives--; m_resume = RES; m_state = RESUME;
          end else begin
            m_lives = 0; m_state = OVER;
          end
        end else if (power_pill) begin
          m_power = POWER;
        end
      end
      RESUME: begin
        m_resume--;
        if (m_resume == 0) m_state = PLAY;
      end
      default: if (start && !m_start_prev) m_state = INIT;
    endcase
    m_prev = coll;
    m_start_prev = start;
  endtask

  task automatic tick();
    model_step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic set_ghost(input int i, input int x, input int y);
    ghost_x[i*XW +: XW] = XW'(x);
    ghost_y[i*YW +: YW] = YW'(y);
  endtask

  task automatic park_ghosts();
    for (int i = 0; i < NG; i++) set_ghost(i, 20 + i, 20 + i);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; power_pill = 1'b0; all_pills = 1'b0;
    pac_x = 6'd5; pac_y = 5'd7;
    park_ghosts();
    model_reset();
    repeat (2) @(posedge CLOCK_50);
    #1;
    n_checks++;
    if (dut_vec() !== {INIT, 3'd3, 3'b110, 1'b0, 3'b000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got %b want %b", dut_vec(),
               {INIT, 3'd3, 3'b110, 1'b0, 3'b000, 1'b0});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (state !== PLAY || lives !== 3'd3 || ghost_enable !== 1'b1 || sprite_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL start_to_play: got state=%0d lives=%0d gen=%b srst=%b want 1 3 1 0",
               state, lives, ghost_enable, sprite_reset);
    end
  endtask

  task automatic test_life_lost();
    int pulses = 0, res_cycles = 0;
    set_ghost(1, 5, 7);
    for (int k = 0; k < 12; k++) begin
      if (k == 3) park_ghosts();
      tick();
      if (life_lost) pulses++;
      if (state == RESUME) res_cycles++;
    end
    n_checks++;
    if (pulses != 1 || lives !== 3'd2) begin
      n_fail++;
      $display("FAIL life_lost_once: got pulses=%0d lives=%0d want 1 2", pulses, lives);
    end
    n_checks++;
    if (res_cycles != RES || state !== PLAY) begin
      n_fail++;
      $display("FAIL resume_length: got %0d cycles end_state=%0d want %0d cycles state 1",
               res_cycles, state, RES);
    end
  endtask

  task automatic test_game_over();
    set_ghost(0, 5, 7);
    tick();
    park_ghosts();
    n_checks++;
    if (lives !== 3'd1 || state !== RESUME) begin
      n_fail++;
      $display("FAIL second_life: got lives=%0d state=%0d want 1 2", lives, state);
    end
    repeat (6) tick();
    start = 1'b1;
    set_ghost(0, 5, 7);
    tick();
    park_ghosts();
    n_checks++;
    if (state !== OVER || lives !== 3'd0 || life_lost !== 1'b1) begin
      n_fail++;
      $display("FAIL game_over: got state=%0d lives=%0d lost=%b want 3 0 1", state, lives, life_lost);
    end
    repeat (3) tick();
    n_checks++;
    if (state !== OVER || map_wr_reset !== 1'b1 || ghost_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL over_held_start: got state=%0d mwr=%b gen=%b want 3 1 0",
               state, map_wr_reset, ghost_enable);
    end
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    n_checks++;
    if (state !== INIT || sprite_reset !== 1'b1 || map_wr_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_init: got state=%0d srst=%b mwr=%b want 0 1 1",
               state, sprite_reset, map_wr_reset);
    end
    tick();
    start = 1'b0;
    n_checks++;
    if (state !== PLAY || lives !== 3'd3) begin
      n_fail++;
      $display("FAIL restart_play: got state=%0d lives=%0d want 1 3", state, lives);
    end
  endtask

  task automatic test_power();
    int fr_cnt = 0, eat_pulses = 0;
    logic [NG-1:0] eaten_seen = '0;
    power_pill = 1'b1;
    tick();
    power_pill = 1'b0;
    if (frightened) fr_cnt++;
    for (int k = 1; k < 15; k++) begin
      if (k == 3) begin set_ghost(0, 5, 7); set_ghost(2, 5, 7); end
      if (k == 5) park_ghosts();
      tick();
      if (frightened) fr_cnt++;
      if (ghost_eaten != '0) begin eat_pulses++; eaten_seen = ghost_eaten; end
      if (life_lost) eat_pulses += 100;
    end
    n_checks++;
    if (fr_cnt != POWER) begin
      n_fail++;
      $display("FAIL frightened_length: got %0d cycles want %0d", fr_cnt, POWER);
    end
    n_checks++;
    if (eat_pulses != 1 || eaten_seen !== 3'b101 || lives !== 3'd3) begin
      n_fail++;
      $display("FAIL ghost_eaten: got pulses=%0d mask=%b lives=%0d want 1 101 3",
               eat_pulses, eaten_seen, lives);
    end
  endtask

  task automatic test_reload_and_pill_hit();
    int fr_cnt;
    power_pill = 1'b1;
    tick();
    power_pill = 1'b0;
    repeat (6) tick();
    power_pill = 1'b1;
    tick();
    power_pill = 1'b0;
    fr_cnt = frightened ? 1 : 0;
    for (int k = 0; k < 11; k++) begin
      tick();
      if (frightened) fr_cnt++;
    end
    n_checks++;
    if (fr_cnt != POWER || frightened !== 1'b0) begin
      n_fail++;
      $display("FAIL pill_reload: got %0d cycles after reload (final %b) want %0d (final 0)",
               fr_cnt, frightened, POWER);
    end
    power_pill = 1'b1;
    set_ghost(1, 5, 7);
    tick();
    power_pill = 1'b0;
    park_ghosts();
    n_checks++;
    if (life_lost !== 1'b1 || frightened !== 1'b0 || state !== RESUME || lives !== 3'd2) begin
      n_fail++;
      $display("FAIL pill_with_hit: got lost=%b fr=%b state=%0d lives=%0d want 1 0 2 2",
               life_lost, frightened, state, lives);
    end
    repeat (6) tick();
    n_checks++;
    if (frightened !== 1'b0 || state !== PLAY) begin
      n_fail++;
      $display("FAIL pill_discarded: got fr=%b state=%0d want 0 1", frightened, state);
    end
  endtask

  task automatic test_win();
    all_pills = 1'b1;
    set_ghost(2, 5, 7);
    tick();
    all_pills = 1'b0;
    park_ghosts();
    n_checks++;
    if (state !== WIN || lives !== 3'd2 || life_lost !== 1'b0 || map_wr_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL win_priority: got state=%0d lives=%0d lost=%b mwr=%b want 4 2 0 1",
               state, lives, life_lost, map_wr_reset);
    end
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    n_checks++;
    if (state !== PLAY || lives !== 3'd3) begin
      n_fail++;
      $display("FAIL win_restart: got state=%0d lives=%0d want 1 3", state, lives);
    end
  endtask

  task automatic test_reset_in_resume();
    power_pill = 1'b0;
    set_ghost(0, 5, 7);
    tick();
    park_ghosts();
    tick();
    #3;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (dut_vec() !== {INIT, 3'd3, 3'b110, 1'b0, 3'b000, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset_resume: got %b want %b", dut_vec(),
               {INIT, 3'd3, 3'b110, 1'b0, 3'b000, 1'b0});
    end
    #2;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      start      = ($urandom_range(0, 3) == 0);
      power_pill = ($urandom_range(0, 7) == 0);
      all_pills  = ($urandom_range(0, 39) == 0);
      pac_x = XW'($urandom_range(0, 1));
      pac_y = YW'($urandom_range(0, 1));
      for (int i = 0; i < NG; i++)
        set_ghost(i, int'($urandom_range(0, 2)), int'($urandom_range(0, 1)));
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: got %b want %b", c, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_life_lost();
    test_game_over();
    test_power();
    test_reload_and_pill_hit();
    test_win();
    test_reset_in_resume();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
# game_state_ctrl

Parametrised game-flow controller for the Pac-Man top level. Sequences INIT/PLAY/RESUME/OVER/WIN, owns the lives counter, and detects pac/ghost collisions for any number of ghosts. Adds a power-pill frightened mode in which colliding ghosts are eaten instead of costing a life. Drives the sprite, map-writer and ghost-AI enables that the top level previously generated inline.

## Interface
- NUM_GHOSTS, 2, number of ghost channels (1..8)
- X_W, 6, grid x coordinate width
- Y_W, 5, grid y coordinate width
- LIVES_INIT, 3, lives loaded in INIT (1..7)
- RESUME_CYCLES, 250000000, RESUME hold length in clocks (5 s at 50 MHz)
- POWER_CYCLES, 400000000, frightened-mode length in clocks
- CLOCK_50  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  start/restart request, level
- power_pill  in  1  one-cycle pulse: pac-man ate a power pill
- all_pills  in  1  level: no pills remain on the map
- pac_x / pac_y  in  X_W / Y_W  next pac-man grid position
- ghost_x / ghost_y  in  NUM_GHOSTS*X_W / NUM_GHOSTS*Y_W  next ghost positions, ghost i in slice i
- state  out  3  current state (package enum)
- lives  out  3  remaining lives
- sprite_reset  out  1  hold sprite controllers at home positions
- map_wr_reset  out  1  hold map RAM writer in reset
- ghost_enable  out  1  ghost AI may move
- frightened  out  1  power mode active
- ghost_eaten  out  NUM_GHOSTS  one-cycle pulse per eaten ghost
- life_lost  out  1  one-cycle pulse on life decrement

## Operation
- Collision i = (ghost_x[i]==pac_x) & (ghost_y[i]==pac_y). Registered previous value per ghost. Only rising edges (hit_i) act, so a sustained overlap counts once.
- INIT: lives<=LIVES_INIT, power timer cleared. sprite_reset=1, map_wr_reset=1, ghost_enable=0. start=1 -> PLAY.
- PLAY: sprite_reset=0, map_wr_reset=0, ghost_enable=1. Priority, highest first:
  - all_pills=1 -> WIN.
  - frightened=1: every hit_i pulses ghost_eaten[i]. No state change.
  - frightened=0 with any hit_i and lives>1: lives-1, life_lost pulse, load resume timer, -> RESUME.
  - frightened=0 with any hit_i and lives==1: lives<=0, life_lost pulse, -> OVER.
  - Multiple ghosts hitting in one cycle cost one life.
- Power timer: power_pill in PLAY loads POWER_CYCLES-1. A pill arriving while already frightened reloads the timer; no accumulation. frightened = timer != 0. The timer decrements only in PLAY, freezes in RESUME, and clears in INIT/OVER/WIN.
- RESUME: sprite_reset=1, map_wr_reset=0, ghost_enable=0. The timer counts down from RESUME_CYCLES-1; at 0 -> PLAY. Collisions are ignored.
- OVER / WIN: ghost_enable=0, sprite_reset=0, map_wr_reset=1. Leave only on a rising edge of start -> INIT. A start held from the previous game does not restart.
- Simultaneous power_pill and hit in the same cycle: the hit uses the registered frightened value, so the life is lost. The pill's load is discarded because the state leaves PLAY.

## Timing
- Reset values: state=INIT, lives=LIVES_INIT, sprite_reset=1, map_wr_reset=1, ghost_enable=0, frightened=0, ghost_eaten=0, life_lost=0. All timers and collision history are 0.
- All outputs are registered (Moore on the state register). A transition triggered in cycle N shows on outputs in cycle N+1. life_lost and ghost_eaten are asserted in N+1 for exactly one cycle.
- frightened rises the cycle after power_pill. It is high for exactly POWER_CYCLES cycles in uninterrupted PLAY.
- RESUME lasts exactly RESUME_CYCLES cycles.
- reset_n low at any time returns immediately to the reset values, including mid-RESUME or mid-power.
- Timer widths are $clog2(max(cycles,2)). No wrap: the down-counters saturate at 0.

## Structure
- Shared package game_pkg holds:
  - the state enum: INIT, PLAY, RESUME, OVER, WIN;
  - the default X_W/Y_W coordinate widths;
  - the LIVES_W=3 constant.
- Sub-module countdown_timer, parameterised by CYCLES, with load/enable/clear inputs and a zero output. It is instantiated twice, once for resume and once for power.
- Collision compare is a generate loop over NUM_GHOSTS.

## Test plan
Bench parameters: NUM_GHOSTS=3, RESUME_CYCLES=4, POWER_CYCLES=8.
- Reset, then start=1 -> state=PLAY next cycle, lives=3, ghost_enable=1, sprite_reset=0.
- Ghost 1 moves onto pac (5,7) for 3 cycles -> one life_lost pulse, lives=2. State is RESUME for exactly 4 cycles, then PLAY.
- Third life lost -> lives=0, state=OVER. With start held high the state stays OVER. start 0 then 1 -> INIT, then PLAY with lives=3.
- power_pill pulse, then ghosts 0 and 2 collide 3 cycles later -> ghost_eaten=3'b101 pulse, lives unchanged. frightened is high for exactly 8 cycles.
- power_pill while frightened with 2 cycles left -> timer reloads and frightened stays high 8 more cycles. power_pill together with a hit while not frightened -> life lost, frightened stays 0.
- all_pills=1 in the same cycle as a non-frightened hit -> WIN, lives unchanged. reset_n low during RESUME -> all outputs at reset values asynchronously.
